mem_bist: RTL and testbench
===========================

MEM_BIST -- requirements
Module: mem_bist

Interface
REQ-001: Parameter PATTERN, default 8'h55, background data pattern written in phase W0.
REQ-002: Parameter STOP_ON_FAIL, default 1'b1; 1 = abort at first mismatch, 0 = run to completion while keeping the first failure.
REQ-003: clk  input  1  single clock; all state updates on posedge clk.
REQ-004: rst_  input  1  reset, asynchronous, active-low.
REQ-005: start  input  1  test request; sampled only in IDLE.
REQ-006: read  output  1  memory read strobe, to mem read.
REQ-007: write  output  1  memory write strobe, to mem write.
REQ-008: addr  output  5  memory address, to mem addr.
REQ-009: data_in  output  8  write data, to mem data_in.
REQ-010: data_out  input  8  read data from mem data_out; valid one cycle after read is asserted.
REQ-011: busy  output  1  high from the first test cycle until DONE is entered.
REQ-012: done  output  1  high in DONE; held until the next accepted start.
REQ-013: pass  output  1  result; meaningful only while done=1.
REQ-014: fail_addr  output  5  address of the first mismatch.
REQ-015: fail_data  output  8  data_out value captured at the first mismatch.

Function
REQ-016: The block SHALL be a registered FSM with states IDLE, W0, R0_RD, R0_CHK, R0_WR, R1_RD, R1_CHK, DONE.
REQ-017: IDLE: start=1 -> W0 with addr=0; busy, done, pass, fail_addr and fail_data are cleared at this edge.
REQ-018: W0: write=1, data_in=PATTERN, one cycle per address, addr 0->31; after addr 31 -> R0_RD with addr=0.
REQ-019: R0_RD: read=1 for one cycle, then R0_CHK.
REQ-020: R0_CHK: read=0, write=0; data_out is compared against PATTERN; then R0_WR.
REQ-021: R0_WR: write=1, data_in=~PATTERN; addr increments and the FSM returns to R0_RD; after addr 31 -> R1_RD with addr=31.
REQ-022: R1_RD/R1_CHK: read for one cycle, then compare against ~PATTERN; addr decrements 31->0; after the addr 0 check -> DONE.
REQ-023: read and write SHALL never be high in the same cycle; both SHALL be 0 in IDLE, DONE and the CHK states.
REQ-024: Total busy duration SHALL be exactly 192 cycles (32 + 96 + 64) when no abort occurs.
REQ-025: Mismatch, first occurrence only: capture fail_addr=addr and fail_data=data_out, and set a sticky fail flag; later mismatches SHALL NOT overwrite the capture.
REQ-026: Mismatch with STOP_ON_FAIL=1: next state is DONE regardless of phase.
REQ-027: Mismatch with STOP_ON_FAIL=0: the sequence continues unchanged.
REQ-028: DONE: busy=0, done=1, pass=~fail.
REQ-029: DONE with start=1 -> W0, restarting as in REQ-017; start while busy SHALL be ignored.
REQ-030: Address counter SHALL NOT wrap during a phase; phase exit is decided on addr 31 (ascending) or addr 0 (descending).
REQ-031: addr and data_in SHALL hold their last value when not strobing; both are 0 in IDLE.

Reset
REQ-032: rst_=0 SHALL immediately, without waiting for clk, force state=IDLE and drive read, write, busy, done, pass, fail flag to 0 and addr, data_in, fail_addr, fail_data to 0.
REQ-033: Reset asserted mid-test SHALL abort the test with no further memory strobes; a new start is required after release.

Verification
REQ-034: Fault-free mem, PATTERN=8'h55, start pulse at edge 0 -> busy=1 from edge 0, done=1 and pass=1 after edge 192, 32 writes of 8'h55 then 32 of 8'hAA observed.
REQ-035: Model bit0 of addr 5 stuck-at-0, STOP_ON_FAIL=1 -> done with pass=0, fail_addr=5, fail_data=8'h54, no strobes at addr 6 or above in R0.
REQ-036: Same fault, STOP_ON_FAIL=0 -> full 192-cycle run, pass=0, fail_addr=5, fail_data=8'h54 (first failure retained).
REQ-037: Assert rst_ at cycle 100 of a run -> all outputs 0 asynchronously; start after release -> clean full run with pass=1.
REQ-038: Pulse start while busy, then again in DONE -> first pulse ignored (run length unchanged), second pulse restarts with done, pass and fail_* cleared.
REQ-039: Every cycle in all scenarios SHALL be checked with an assertion that read and write are never both high.

Source files
------------

// File: rtl/mem_bist_if.sv
// Memory-side bus between the BIST controller (master) and the memory under test (slave).
interface mem_bist_if;
  logic       read;
  logic       write;
  logic [4:0] addr;
  logic [7:0] data_in;
  logic [7:0] data_out;

  modport master (
    output read,
    output write,
    output addr,
    output data_in,
    input  data_out
  );

  modport slave (
    input  read,
    input  write,
    input  addr,
    input  data_in,
    output data_out
  );
endinterface

// File: rtl/mem_bist.sv
// March-style BIST for a 32x8 memory: write background, read/invert ascending, read descending.
// Records the first mismatch; optionally aborts on it.
module mem_bist #(
  parameter logic [7:0] PATTERN      = 8'h55,
  parameter bit         STOP_ON_FAIL = 1'b1
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              start,
  mem_bist_if.master        mem,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [4:0]        fail_addr,
  output logic [7:0]        fail_data
);

  typedef enum logic [2:0] {
    StIdle,
    StW0,
    StR0Rd,
    StR0Chk,
    StR0Wr,
    StR1Rd,
    StR1Chk,
    StDone
  } state_e;

  state_e     state_q, state_d;
  logic [4:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic       fail_q, fail_d;
  logic [4:0] fail_addr_q, fail_addr_d;
  logic [7:0] fail_data_q, fail_data_d;
  logic       mismatch;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      data_q      <= '0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    mismatch    = 1'b0;

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d     = StW0;
          addr_d      = '0;
          data_d      = PATTERN;
          fail_d      = 1'b0;
          fail_addr_d = '0;
          fail_data_d = '0;
        end
      end
      StW0: begin
        if (addr_q == 5'd31) begin
          state_d = StR0Rd;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + 5'd1;
        end
      end
      StR0Rd: state_d = StR0Chk;
      StR0Chk: begin
        mismatch = (mem.data_out != PATTERN);
        if (mismatch && STOP_ON_FAIL) begin
          state_d = StDone;
        end else begin
          state_d = StR0Wr;
          data_d  = ~PATTERN;
        end
      end
      StR0Wr: begin
        // addr is already 31 on the last write, which is where R1 starts
        if (addr_q == 5'd31) begin
          state_d = StR1Rd;
        end else begin
          state_d = StR0Rd;
          addr_d  = addr_q + 5'd1;
        end
      end
      StR1Rd: state_d = StR1Chk;
      StR1Chk: begin
        mismatch = (mem.data_out != ~PATTERN);
        if ((mismatch && STOP_ON_FAIL) || addr_q == 5'd0) begin
          state_d = StDone;
        end else begin
          state_d = StR1Rd;
          addr_d  = addr_q - 5'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Only the first mismatch of a run is recorded
    if (mismatch && !fail_q) begin
      fail_d      = 1'b1;
      fail_addr_d = addr_q;
      fail_data_d = mem.data_out;
    end
  end

  always_comb begin
    mem.read    = (state_q == StR0Rd) || (state_q == StR1Rd);
    mem.write   = (state_q == StW0) || (state_q == StR0Wr);
    mem.addr    = addr_q;
    mem.data_in = data_q;
    busy        = (state_q != StIdle) && (state_q != StDone);
    done        = (state_q == StDone);
    pass        = (state_q == StDone) && !fail_q;
    fail_addr   = fail_addr_q;
    fail_data   = fail_data_q;
  end

endmodule

// File: tb/tb_mem_bist.sv
// Directed bench for mem_bist: two instances (abort / run-to-completion) on faultable memory models,
// with a write scoreboard and per-cycle read/write exclusivity checks.
module tb_mem_bist;

  logic       clk = 1'b0;
  logic       rst_;
  logic       start_a, start_b;
  logic       busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic [4:0] fail_addr_a, fail_addr_b;
  logic [7:0] fail_data_a, fail_data_b;

  mem_bist_if bus_a ();
  mem_bist_if bus_b ();

  mem_bist #(.PATTERN(8'h55), .STOP_ON_FAIL(1'b1)) dut_a (
    .clk       (clk),
    .rst_      (rst_),
    .start     (start_a),
    .mem       (bus_a),
    .busy      (busy_a),
    .done      (done_a),
    .pass      (pass_a),
    .fail_addr (fail_addr_a),
    .fail_data (fail_data_a)
  );

  mem_bist #(.PATTERN(8'h55), .STOP_ON_FAIL(1'b0)) dut_b (
    .clk       (clk),
    .rst_      (rst_),
    .start     (start_b),
    .mem       (bus_b),
    .busy      (busy_b),
    .done      (done_b),
    .pass      (pass_b),
    .fail_addr (fail_addr_b),
    .fail_data (fail_data_b)
  );

  always #5 clk = ~clk;

  // Memory models: bit0 of addr 5 and bit1 of addr 9 can be made stuck-at-0
  logic [7:0] mem_a [32];
  logic [7:0] mem_b [32];
  bit         fault5_a, fault5_b, fault9_b;

  function automatic logic [7:0] stuck(input logic [4:0] a, input logic [7:0] d,
                                       input bit f5, input bit f9);
    logic [7:0] r;
    r = d;
    if (f5 && a == 5'd5) r[0] = 1'b0;
    if (f9 && a == 5'd9) r[1] = 1'b0;
    return r;
  endfunction

  always @(posedge clk) begin
    if (bus_a.write) mem_a[bus_a.addr] <= stuck(bus_a.addr, bus_a.data_in, fault5_a, 1'b0);
    if (bus_a.read)  bus_a.data_out <= mem_a[bus_a.addr];
    if (bus_b.write) mem_b[bus_b.addr] <= stuck(bus_b.addr, bus_b.data_in, fault5_b, fault9_b);
    if (bus_b.read)  bus_b.data_out <= mem_b[bus_b.addr];
  end

  int          checks   = 0;
  int          failures = 0;
  int          reads_a, reads_b;
  logic [12:0] q_a [$];
  logic [12:0] q_b [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; sample on the falling edge
  task automatic step();
    logic [12:0] e;
    @(negedge clk);
    chk("rw_excl_a", 32'(bus_a.read & bus_a.write), 32'd0);
    chk("rw_excl_b", 32'(bus_b.read & bus_b.write), 32'd0);
    if (bus_a.read) reads_a++;
    if (bus_b.read) reads_b++;
    if (bus_a.write) begin
      chk("wr_a_expected", 32'(q_a.size() != 0), 32'd1);
      if (q_a.size() != 0) begin
        e = q_a.pop_front();
        chk("wr_a", 32'({bus_a.addr, bus_a.data_in}), 32'(e));
      end
    end
    if (bus_b.write) begin
      chk("wr_b_expected", 32'(q_b.size() != 0), 32'd1);
      if (q_b.size() != 0) begin
        e = q_b.pop_front();
        chk("wr_b", 32'({bus_b.addr, bus_b.data_in}), 32'(e));
      end
    end
  endtask

  // W0 background writes, then inverted writes at addr 0..n_inv-1
  task automatic push_writes(input bit sel, input int n_inv);
    for (int i = 0; i < 32; i++) begin
      if (sel) q_b.push_back({5'(i), 8'h55}); else q_a.push_back({5'(i), 8'h55});
    end
    for (int i = 0; i < n_inv; i++) begin
      if (sel) q_b.push_back({5'(i), 8'hAA}); else q_a.push_back({5'(i), 8'hAA});
    end
  endtask

  task automatic reset_outputs_zero(input string tag);
    chk({tag, "_read"},      32'(bus_a.read),    32'd0);
    chk({tag, "_write"},     32'(bus_a.write),   32'd0);
    chk({tag, "_addr"},      32'(bus_a.addr),    32'd0);
    chk({tag, "_data_in"},   32'(bus_a.data_in), 32'd0);
    chk({tag, "_busy"},      32'(busy_a),        32'd0);
    chk({tag, "_done"},      32'(done_a),        32'd0);
    chk({tag, "_pass"},      32'(pass_a),        32'd0);
    chk({tag, "_fail_addr"}, 32'(fail_addr_a),   32'd0);
    chk({tag, "_fail_data"}, 32'(fail_data_a),   32'd0);
  endtask

  // Pulse start on one instance and count busy cycles until done (bounded)
  task automatic run(input bit sel, input int pulse_at, output int busy_n);
    bit seen;
    busy_n  = 0;
    seen    = 1'b0;
    reads_a = 0;
    reads_b = 0;
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    step();
    start_a = 1'b0;
    start_b = 1'b0;
    chk("start_busy",      32'(sel ? busy_b : busy_a),           32'd1);
    chk("start_done_clr",  32'(sel ? done_b : done_a),           32'd0);
    chk("start_pass_clr",  32'(sel ? pass_b : pass_a),           32'd0);
    chk("start_faddr_clr", 32'(sel ? fail_addr_b : fail_addr_a), 32'd0);
    chk("start_fdata_clr", 32'(sel ? fail_data_b : fail_data_a), 32'd0);
    for (int c = 0; c < 400; c++) begin
      if (sel ? done_b : done_a) begin
        seen = 1'b1;
        break;
      end
      if (sel ? busy_b : busy_a) busy_n++;
      if (sel) start_b = (c == pulse_at); else start_a = (c == pulse_at);
      step();
    end
    start_a = 1'b0;
    start_b = 1'b0;
    chk("done_within_bound", 32'(seen), 32'd1);
  endtask

  initial begin
    int bn;
    rst_     = 1'b0;
    start_a  = 1'b0;
    start_b  = 1'b0;
    fault5_a = 1'b0;
    fault5_b = 1'b0;
    fault9_b = 1'b0;
    #1;
    reset_outputs_zero("reset");
    step();
    step();
    rst_ = 1'b1;
    step();
    chk("idle_busy", 32'(busy_a), 32'd0);

    // Fault-free full run
    push_writes(1'b0, 32);
    run(1'b0, -1, bn);
    chk("clean_busy_len", 32'(bn),          32'd192);
    chk("clean_done",     32'(done_a),      32'd1);
    chk("clean_pass",     32'(pass_a),      32'd1);
    chk("clean_reads",    32'(reads_a),     32'd64);
    chk("clean_wr_left",  32'(q_a.size()),  32'd0);
    step();
    step();
    chk("done_held",      32'(done_a),      32'd1);
    chk("pass_held",      32'(pass_a),      32'd1);

    // Stuck bit at addr 5, abort on first mismatch
    fault5_a = 1'b1;
    push_writes(1'b0, 5);
    run(1'b0, -1, bn);
    chk("abort_busy_len", 32'(bn),          32'd49);
    chk("abort_pass",     32'(pass_a),      32'd0);
    chk("abort_faddr",    32'(fail_addr_a), 32'd5);
    chk("abort_fdata",    32'(fail_data_a), 32'h54);
    chk("abort_reads",    32'(reads_a),     32'd6);
    chk("abort_wr_left",  32'(q_a.size()),  32'd0);

    // Start while busy is ignored; restart from DONE clears the previous failure
    push_writes(1'b0, 5);
    run(1'b0, 20, bn);
    chk("busy_start_len", 32'(bn),          32'd49);
    chk("busy_start_fa",  32'(fail_addr_a), 32'd5);
    fault5_a = 1'b0;
    push_writes(1'b0, 32);
    run(1'b0, -1, bn);
    chk("restart_len",    32'(bn),          32'd192);
    chk("restart_pass",   32'(pass_a),      32'd1);
    chk("restart_faddr",  32'(fail_addr_a), 32'd0);

    // Same fault, run to completion
    fault5_b = 1'b1;
    push_writes(1'b1, 32);
    run(1'b1, -1, bn);
    chk("nostop_len",     32'(bn),          32'd192);
    chk("nostop_pass",    32'(pass_b),      32'd0);
    chk("nostop_faddr",   32'(fail_addr_b), 32'd5);
    chk("nostop_fdata",   32'(fail_data_b), 32'h54);
    chk("nostop_reads",   32'(reads_b),     32'd64);
    chk("nostop_wr_left", 32'(q_b.size()),  32'd0);

    // Second fault found later in R1 must not overwrite the first capture
    fault9_b = 1'b1;
    push_writes(1'b1, 32);
    run(1'b1, -1, bn);
    chk("two_len",        32'(bn),          32'd192);
    chk("two_pass",       32'(pass_b),      32'd0);
    chk("two_faddr",      32'(fail_addr_b), 32'd5);
    chk("two_fdata",      32'(fail_data_b), 32'h54);

    // Asynchronous reset at cycle 100 of a run
    push_writes(1'b0, 32);
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int i = 0; i < 100; i++) step();
    chk("mid_busy", 32'(busy_a), 32'd1);
    #2 rst_ = 1'b0;
    #1;
    reset_outputs_zero("midreset");
    q_a.delete();
    step();
    step();
    rst_ = 1'b1;
    reads_a = 0;
    for (int i = 0; i < 5; i++) step();
    chk("post_rst_busy",  32'(busy_a),      32'd0);
    chk("post_rst_done",  32'(done_a),      32'd0);
    chk("post_rst_reads", 32'(reads_a),     32'd0);
    push_writes(1'b0, 32);
    run(1'b0, -1, bn);
    chk("after_rst_len",  32'(bn),          32'd192);
    chk("after_rst_pass", 32'(pass_a),      32'd1);
    chk("after_rst_left", 32'(q_a.size()),  32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
